// File: rtl/irq_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt controller: source count, CPU bus
//   register map and the request FSM state encoding.
// ---------------------------------------------------------------------------
package irq_pkg;

    localparam int NUM_SRC = 32;

    // Each region is four consecutive bytes; byte b of a region lives at BASE+b.
    localparam logic [23:0] ADDR_PRIO_BASE = 24'h00_2020;
    localparam logic [23:0] ADDR_EN_BASE   = 24'h00_2024;
    localparam logic [23:0] ADDR_ACT_BASE  = 24'h00_2028;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_CLR = 2'd2
    } irq_state_e;

endpackage

// File: rtl/irq_prio_encoder.sv
// ---------------------------------------------------------------------------
// irq_prio_encoder
//   Combinational winner select among candidate interrupt sources.
//   The highest priority value wins; on equal priority the lowest index wins.
//
//   Ports:
//     cand      - one bit per source, 1 = source is eligible
//     prio      - 2-bit priority of each source
//     any_valid - at least one candidate present
//     win_idx   - index of the winning source (0 when none)
// ---------------------------------------------------------------------------
module irq_prio_encoder #(
    parameter int NUM_SRC = 32,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]      cand,
    input  logic [NUM_SRC-1:0][1:0] prio,
    output logic                    any_valid,
    output logic [IDX_W-1:0]        win_idx
);

    logic [1:0] best;

    // Scan from the top index down; '>=' lets a lower index replace an
    // equal-priority winner, which yields the lowest index on ties.
    always_comb begin
        any_valid = 1'b0;
        win_idx   = '0;
        best      = '0;
        for (int n = NUM_SRC - 1; n >= 0; n--) begin
            if (cand[n] && (!any_valid || prio[n] >= best)) begin
                any_valid = 1'b1;
                win_idx   = IDX_W'(n);
                best      = prio[n];
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Interrupt controller for 32 level-pulse sources. Each source is
//   synchronized, rising-edge detected and latched into an active flag.
//   Sources are filtered by enable and a per-group (4 sources) priority
//   against the CPU mask level; the winner is presented to the CPU with a
//   req/ack handshake.
//
//   Ports:
//     clk, reset, clk_ce     - clock, async active-high reset, clock enable
//     bus_write, bus_read    - CPU bus strobes
//     bus_address_in[23:0]   - CPU address
//     bus_data_in[7:0]       - write data
//     bus_data_out[7:0]      - read data (combinational, 0 when unmapped)
//     irq_sources[31:0]      - peripheral interrupt pulses
//     cpu_level[1:0]         - current CPU interrupt mask level
//     irq_req, irq_vector    - request and latched source index to CPU
//     irq_ack                - CPU acknowledge
//
//   Register map (byte wide, little-endian within each 32-bit register):
//     0x2020..0x2023 priority, 2 bits per group of 4 sources
//                    (bytes 0x2022/0x2023 are plain storage, no groups)
//     0x2024..0x2027 enable
//     0x2028..0x202B active, write-1-to-clear
// ---------------------------------------------------------------------------
module irq_controller #(
    parameter int NUM_SRC = irq_pkg::NUM_SRC
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk_ce,
    input  logic                       bus_write,
    input  logic                       bus_read,
    input  logic [23:0]                bus_address_in,
    input  logic [7:0]                 bus_data_in,
    output logic [7:0]                 bus_data_out,
    input  logic [NUM_SRC-1:0]         irq_sources,
    input  logic [1:0]                 cpu_level,
    output logic                       irq_req,
    output logic [$clog2(NUM_SRC)-1:0] irq_vector,
    input  logic                       irq_ack
);

    import irq_pkg::*;

    localparam int IDX_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;
    logic [NUM_SRC-1:0] prev_q, prev_d;
    logic [1:0]         arm_cnt_q, arm_cnt_d;
    logic [31:0]        prio_q, prio_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] active_q, active_d;
    irq_state_e         state_q, state_d;
    logic [IDX_W-1:0]   vec_q, vec_d;

    logic [NUM_SRC-1:0]      rise;
    logic [NUM_SRC-1:0]      clr_mask;
    logic [NUM_SRC-1:0][1:0] prio_src;
    logic [NUM_SRC-1:0]      cand;
    logic                    win_any;
    logic [IDX_W-1:0]        win_idx;
    logic [7:0]              rd_data;

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            arm_cnt_q <= '0;
            prio_q    <= '0;
            enable_q  <= '0;
            active_q  <= '0;
            state_q   <= ST_IDLE;
            vec_q     <= '0;
        end else if (clk_ce) begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            arm_cnt_q <= arm_cnt_d;
            prio_q    <= prio_d;
            enable_q  <= enable_d;
            active_q  <= active_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
        end
    end

    // -----------------------------------------------------------------------
    // Synchronizer and edge detect
    // -----------------------------------------------------------------------
    // After reset the chain holds zeros, so a source that is already high
    // would look like a rising edge. Edge detection stays off until three
    // enabled cycles have passed and prev_q holds a genuinely sampled value.
    always_comb begin
        sync1_d   = irq_sources;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        arm_cnt_d = (arm_cnt_q == 2'd3) ? arm_cnt_q : arm_cnt_q + 2'd1;
        rise      = (arm_cnt_q == 2'd3) ? (sync2_q & ~prev_q) : '0;
    end

    // -----------------------------------------------------------------------
    // Register writes
    // -----------------------------------------------------------------------
    always_comb begin
        prio_d   = prio_q;
        enable_d = enable_q;
        clr_mask = '0;
        if (bus_write) begin
            for (int b = 0; b < 4; b++) begin
                if (bus_address_in == ADDR_PRIO_BASE + 24'(b))
                    prio_d[8*b +: 8] = bus_data_in;
                if (bus_address_in == ADDR_EN_BASE + 24'(b))
                    enable_d[8*b +: 8] = bus_data_in;
                if (bus_address_in == ADDR_ACT_BASE + 24'(b))
                    clr_mask[8*b +: 8] = bus_data_in;
            end
        end
        // Set is applied after clear so a same-cycle edge is never lost.
        active_d = (active_q & ~clr_mask) | rise;
    end

    // -----------------------------------------------------------------------
    // Register reads
    // -----------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        for (int b = 0; b < 4; b++) begin
            if (bus_address_in == ADDR_PRIO_BASE + 24'(b))
                rd_data = prio_q[8*b +: 8];
            if (bus_address_in == ADDR_EN_BASE + 24'(b))
                rd_data = enable_q[8*b +: 8];
            if (bus_address_in == ADDR_ACT_BASE + 24'(b))
                rd_data = active_q[8*b +: 8];
        end
        bus_data_out = bus_read ? rd_data : 8'h00;
    end

    // -----------------------------------------------------------------------
    // Candidate qualification and winner select
    // -----------------------------------------------------------------------
    // Priority 0 can never exceed cpu_level, so it is never eligible.
    always_comb begin
        for (int n = 0; n < NUM_SRC; n++) begin
            prio_src[n] = prio_q[2*(n/4) +: 2];
            cand[n]     = active_q[n] & enable_q[n] & (prio_src[n] > cpu_level);
        end
    end

    irq_prio_encoder #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_prio_enc (
        .cand      (cand),
        .prio      (prio_src),
        .any_valid (win_any),
        .win_idx   (win_idx)
    );

    // -----------------------------------------------------------------------
    // Request FSM
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        irq_req = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_REQ;
                    vec_d   = win_idx;
                end
            end
            ST_REQ: begin
                irq_req = 1'b1;
                // An ack takes precedence over the source disappearing in
                // the same cycle: the CPU has already committed to it.
                if (irq_ack)
                    state_d = ST_WAIT_CLR;
                else if (!cand[vec_q])
                    state_d = ST_IDLE;
            end
            ST_WAIT_CLR: begin
                if (!active_q[vec_q])
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign irq_vector = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_irq_controller
//   Scoreboard bench: stimulus pushes expected read data / request state into
//   queues, a monitor pops and compares whenever a read or request probe is
//   presented. Expected values come from a register-level reference model.
// ---------------------------------------------------------------------------
module tb_irq_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        clk_ce;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [31:0] irq_sources;
    logic [1:0]  cpu_level;
    logic        irq_req;
    logic [4:0]  irq_vector;
    logic        irq_ack;

    always #5 clk = ~clk;

    irq_controller #(.NUM_SRC(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_ce         (clk_ce),
        .bus_write      (bus_write),
        .bus_read       (bus_read),
        .bus_address_in (bus_address_in),
        .bus_data_in    (bus_data_in),
        .bus_data_out   (bus_data_out),
        .irq_sources    (irq_sources),
        .cpu_level      (cpu_level),
        .irq_req        (irq_req),
        .irq_vector     (irq_vector),
        .irq_ack        (irq_ack)
    );

    typedef struct {
        string      name;
        logic [7:0] val;
    } rd_exp_t;

    typedef struct {
        string      name;
        logic       req;
        logic [4:0] vec;
        bit         chk_vec;
    } irq_exp_t;

    rd_exp_t  rd_q[$];
    irq_exp_t irq_q[$];
    logic     irq_probe = 1'b0;
    bit       done = 1'b0;
    int       n_chk = 0;
    int       n_pass = 0;

    // Reference model: architectural register contents only.
    logic [31:0] m_prio, m_en, m_act;

    function automatic logic [7:0] m_byte(input logic [23:0] a);
        logic [31:0] t;
        t = 32'h0;
        if (a >= 24'h2020 && a <= 24'h2023) t = m_prio >> (8 * int'(a - 24'h2020));
        if (a >= 24'h2024 && a <= 24'h2027) t = m_en   >> (8 * int'(a - 24'h2024));
        if (a >= 24'h2028 && a <= 24'h202B) t = m_act  >> (8 * int'(a - 24'h2028));
        return t[7:0];
    endfunction

    // Winner: search priority levels from highest down to just above the
    // mask level; first enabled+active source at that level wins.
    function automatic int m_winner(input logic [1:0] lvl);
        for (int p = 3; p > int'(lvl); p--) begin
            for (int n = 0; n < 32; n++) begin
                if (m_act[n] && m_en[n] && int'(m_prio[2*(n/4) +: 2]) == p)
                    return n;
            end
        end
        return -1;
    endfunction

    // Monitor: compares whatever the DUT presents under a read or probe.
    always @(negedge clk) begin
        rd_exp_t  re;
        irq_exp_t ie;
        if (bus_read) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                $display("FAIL rd_unexpected: got %02h, no expectation queued", bus_data_out);
            end else begin
                re = rd_q.pop_front();
                if (bus_data_out === re.val) n_pass++;
                else $display("FAIL %s: read %02h, expected %02h", re.name, bus_data_out, re.val);
            end
        end
        if (irq_probe) begin
            n_chk++;
            if (irq_q.size() == 0) begin
                $display("FAIL irq_unexpected: req=%0b vec=%0d, no expectation queued", irq_req, irq_vector);
            end else begin
                ie = irq_q.pop_front();
                if (irq_req === ie.req && (!ie.chk_vec || irq_vector === ie.vec)) n_pass++;
                else $display("FAIL %s: req=%0b vec=%0d, expected req=%0b vec=%0d",
                              ie.name, irq_req, irq_vector, ie.req, ie.vec);
            end
        end
        if (done) begin
            n_chk++;
            if (rd_q.size() == 0 && irq_q.size() == 0) n_pass++;
            else $display("FAIL leftover: %0d reads, %0d probes never presented", rd_q.size(), irq_q.size());
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $finish;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        bus_read  = 1'b0;
        bus_write = 1'b0;
        irq_probe = 1'b0;
        irq_ack   = 1'b0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [23:0] a, input logic [7:0] d);
        int b;
        bus_address_in = a;
        bus_data_in    = d;
        bus_write      = 1'b1;
        if (a >= 24'h2020 && a <= 24'h2023) begin b = int'(a - 24'h2020); m_prio[8*b +: 8] = d; end
        if (a >= 24'h2024 && a <= 24'h2027) begin b = int'(a - 24'h2024); m_en[8*b +: 8]   = d; end
        if (a >= 24'h2028 && a <= 24'h202B) begin b = int'(a - 24'h2028); m_act[8*b +: 8]  = m_act[8*b +: 8] & ~d; end
        step();
    endtask

    task automatic rd(input string name, input logic [23:0] a);
        bus_address_in = a;
        bus_read       = 1'b1;
        rd_q.push_back('{name, m_byte(a)});
        step();
    endtask

    // Arms a request probe for the current cycle; the caller advances time.
    task automatic probe(input string name, input logic req, input int vec, input bit chk_vec);
        irq_probe = 1'b1;
        irq_q.push_back('{name, req, 5'(vec), chk_vec});
    endtask

    task automatic pulse_wait(input logic [31:0] mask);
        irq_sources = mask;
        steps(4);
        irq_sources = '0;
        m_act = m_act | mask;
    endtask

    task automatic quiesce();
        for (int b = 0; b < 4; b++) wr(24'h2024 + 24'(b), 8'h00);
        for (int b = 0; b < 4; b++) wr(24'h2028 + 24'(b), 8'hFF);
        steps(2);
    endtask

    task automatic rd_all(input string name);
        for (int a = 'h2020; a <= 'h202B; a++) rd(name, 24'(a));
    endtask

    initial begin
        int w;
        logic [31:0] mask;
        reset = 1'b1; clk_ce = 1'b1; bus_write = 1'b0; bus_read = 1'b0;
        bus_address_in = '0; bus_data_in = '0; irq_sources = '0;
        cpu_level = 2'd0; irq_ack = 1'b0;
        m_prio = '0; m_en = '0; m_act = '0;
        steps(2);
        reset = 1'b0;
        steps(4);

        // Reset state and unmapped addresses
        probe("rst_req", 1'b0, 0, 1'b1); step();
        rd_all("rst_reg");
        rd("unmapped_202c", 24'h00_202C);
        rd("unmapped_201f", 24'h00_201F);
        rd("unmapped_hi",   24'hFF_2020);

        // Scenario 1: latency from source edge to active and to irq_req
        wr(24'h2020, 8'h03);
        wr(24'h2024, 8'h01);
        cpu_level   = 2'd0;
        irq_sources = 32'h1;
        steps(2);
        rd("s1_act_early", 24'h2028);
        m_act = 32'h1;
        probe("s1_req_not_yet", 1'b0, 0, 1'b0);
        rd("s1_act", 24'h2028);
        probe("s1_req", 1'b1, 0, 1'b1); step();
        irq_sources = '0;
        quiesce();

        // Scenario 2: higher priority wins, then the other is served
        wr(24'h2020, 8'h09);
        pulse_wait(32'h22);
        wr(24'h2024, 8'h22);
        step();
        probe("s2_vec5", 1'b1, 5, 1'b1); step();
        wr(24'h2028, 8'h20);
        steps(2);
        probe("s2_vec1", 1'b1, 1, 1'b1);
        rd("s2_act", 24'h2028);
        quiesce();

        // Scenario 3: priority must exceed cpu_level
        wr(24'h2020, 8'h02);
        cpu_level = 2'd2;
        wr(24'h2024, 8'h01);
        pulse_wait(32'h1);
        step();
        probe("s3_masked", 1'b0, 0, 1'b0); step();
        cpu_level = 2'd1;
        step();
        probe("s3_unmasked", 1'b1, 0, 1'b1); step();
        cpu_level = 2'd0;
        quiesce();

        // Scenario 4: same-cycle edge and write-1-clear, set wins
        irq_sources = 32'h4;
        steps(2);
        wr(24'h2028, 8'h04);
        m_act = m_act | 32'h4;
        irq_sources = '0;
        rd("s4_set_wins", 24'h2028);
        quiesce();

        // Scenario 5: ack -> WAIT_CLR -> clear -> IDLE; enable drop w/o ack
        wr(24'h2020, 8'h03);
        wr(24'h2024, 8'h01);
        pulse_wait(32'h1);
        step();
        probe("s5_req", 1'b1, 0, 1'b1); step();
        irq_ack = 1'b1; step();
        probe("s5_wait", 1'b0, 0, 1'b0); step();
        probe("s5_wait_hold", 1'b0, 0, 1'b0);
        rd("s5_act_kept", 24'h2028);
        wr(24'h2028, 8'h01);
        step();
        probe("s5_idle", 1'b0, 0, 1'b0); step();
        pulse_wait(32'h1);
        step();
        probe("s5_req2", 1'b1, 0, 1'b1); step();
        wr(24'h2024, 8'h00);
        step();
        probe("s5_en_drop", 1'b0, 0, 1'b0); step();
        wr(24'h2024, 8'h01);
        step();
        probe("s5_rereq", 1'b1, 0, 1'b1); step();

        // Scenario 6: reset during REQ, sources held high across release
        reset = 1'b1;
        irq_sources = 32'hFFFF_FFFF;
        m_prio = '0; m_en = '0; m_act = '0;
        #1;
        probe("s6_req_async", 1'b0, 0, 1'b1);
        rd_all("s6_reg");
        reset = 1'b0;
        steps(8);
        for (int b = 0; b < 4; b++) rd("s6_no_spurious", 24'h2028 + 24'(b));
        irq_sources = '0;
        steps(4);

        // Clock enable low: writes are ignored
        clk_ce = 1'b0;
        bus_address_in = 24'h2024; bus_data_in = 8'hAA; bus_write = 1'b1;
        step();
        clk_ce = 1'b1;
        rd("ce_hold", 24'h2024);

        // Randomized trials: full serve order against the model
        for (int t = 0; t < 20; t++) begin
            quiesce();
            cpu_level = 2'($urandom_range(0, 3));
            for (int b = 0; b < 4; b++) wr(24'h2020 + 24'(b), 8'($urandom));
            for (int b = 0; b < 4; b++) wr(24'h2024 + 24'(b), 8'($urandom));
            mask = $urandom;
            pulse_wait(mask);
            step();
            for (int b = 0; b < 4; b++) rd("rnd_act", 24'h2028 + 24'(b));
            rd("rnd_prio0", 24'h2020);
            for (int k = 0; k < 33; k++) begin
                w = m_winner(cpu_level);
                if (w < 0) begin
                    probe("rnd_none", 1'b0, 0, 1'b0); step();
                    break;
                end
                probe("rnd_win", 1'b1, w, 1'b1); step();
                irq_ack = 1'b1; step();
                probe("rnd_wait", 1'b0, 0, 1'b0); step();
                wr(24'h2028 + 24'(w / 8), 8'(1 << (w % 8)));
                steps(2);
            end
        end

        step();
        done = 1'b1;
        steps(2);
    end

endmodule
